// File: rtl/ripple4_gate_pkg.sv
// Shared constants and types for the 4-bit gate-level ripple adder.
package ripple4_gate_pkg;

    // Operand width of the reference adder. Only 4 is built and verified.
    localparam int RIPPLE4_WIDTH = 4;

    // One adder result as captured by the output register.
    typedef struct packed {
        logic                     cout;
        logic [RIPPLE4_WIDTH-1:0] sum;
    } adder_result_t;

    // Bundle a carry and a sum into a result record.
    function automatic adder_result_t make_result(
        input logic                     cout,
        input logic [RIPPLE4_WIDTH-1:0] sum
    );
        adder_result_t r;
        r.cout = cout;
        r.sum  = sum;
        return r;
    endfunction

endpackage

// File: rtl/ripple4_gate_full_adder_gate.sv
// One full-adder cell built only from xor/and/or gate primitives.
// s  = a ^ b ^ ci
// co = (a & b) | (ci & (a ^ b))
module full_adder_gate (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    wire half_sum;
    wire gen_term;
    wire prop_term;

    // The half sum is shared by the sum output and the propagate term.
    xor g_half (half_sum, a, b);
    xor g_sum  (s, half_sum, ci);
    and g_gen  (gen_term, a, b);
    and g_prop (prop_term, ci, half_sum);
    or  g_co   (co, gen_term, prop_term);

endmodule

// File: rtl/ripple4_gate.sv
// 4-bit ripple-carry adder made of gate-level full-adder cells, with the
// sum and carry-out captured in an output register (one cycle latency).
module ripple4_gate
    import ripple4_gate_pkg::*;
#(
    parameter int WIDTH = RIPPLE4_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             Cin,
    output logic [WIDTH-1:0] outS2,
    output logic             Cout0
);

    // carry[i] feeds bit i; carry[WIDTH] is the carry out of the top bit.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;
    adder_result_t    next_result;

    assign carry[0] = Cin;

    // Chain the cells: each cell's carry-in is the previous cell's carry-out.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_gate u_fa (
            .a  (inA[i]),
            .b  (inB[i]),
            .ci (carry[i]),
            .s  (sum_bits[i]),
            .co (carry[i+1])
        );
    end

    assign next_result = make_result(carry[WIDTH], sum_bits);

    // Output register: reset clears the result regardless of the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            outS2 <= '0;
            Cout0 <= 1'b0;
        end else begin
            outS2 <= next_result.sum;
            Cout0 <= next_result.cout;
        end
    end

endmodule

// File: tb/tb_ripple4_gate.sv
// Directed bench for ripple4_gate: a table of hand-computed vectors, an
// exhaustive sweep with a mid-stream reset, and an input-glitch sequence.
module tb_ripple4_gate;

    logic       clk;
    logic       rst;
    logic [3:0] inA;
    logic [3:0] inB;
    logic       Cin;
    logic [3:0] outS2;
    logic       Cout0;

    int errors = 0;
    int checks = 0;

    logic [4:0] exp_q[$];

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       c;
    } vec_t;

    vec_t vecs[$];

    ripple4_gate dut (
        .clk   (clk),
        .rst   (rst),
        .inA   (inA),
        .inB   (inB),
        .Cin   (Cin),
        .outS2 (outS2),
        .Cout0 (Cout0)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst = 1'b1;
        inA = 4'hF;
        inB = 4'hF;
        Cin = 1'b1;
    end

    // driver tasks
    task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b, input logic c);
        rst = r;
        inA = a;
        inB = b;
        Cin = c;
    endtask

    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] r;
        r = {1'b0, a} + {1'b0, b} + {4'b0, c};
        return r;
    endfunction

    task automatic add_vec(input string name, input logic r, input logic [3:0] a,
                           input logic [3:0] b, input logic c, input logic [3:0] s, input logic co);
        vec_t v;
        v.name = name; v.rst = r; v.a = a; v.b = b; v.cin = c; v.s = s; v.c = co;
        vecs.push_back(v);
    endtask

    // scoreboard compare
    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] got;
        got = {Cout0, outS2};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got S=%h C=%b, expected S=%h C=%b",
                     name, got[3:0], got[4], exp[3:0], exp[4]);
        end
    endtask

    task automatic check_from_queue(input string name);
        logic [4:0] exp;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: got empty expected queue, expected one entry", name);
        end else begin
            exp = exp_q.pop_front();
            check(name, exp);
        end
    endtask

    initial begin
        // name                rst  a     b     cin  s     c
        add_vec("reset_edge1", 1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0);
        add_vec("reset_edge2", 1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0);
        add_vec("3p5p0",       1'b0, 4'h3, 4'h5, 1'b0, 4'h8, 1'b0);
        add_vec("9p6p1",       1'b0, 4'h9, 4'h6, 1'b1, 4'h0, 1'b1);
        add_vec("Fp0p1_ripple",1'b0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1);
        add_vec("FpFp1_max",   1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
        add_vec("0p0p0_zero",  1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        add_vec("Fp1p0_wrap",  1'b0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
        add_vec("7p8p0",       1'b0, 4'h7, 4'h8, 1'b0, 4'hF, 1'b0);
        add_vec("Ap5p1",       1'b0, 4'hA, 4'h5, 1'b1, 4'h0, 1'b1);
        add_vec("0p0p1_cin",   1'b0, 4'h0, 4'h0, 1'b1, 4'h1, 1'b0);
        add_vec("rst_wins",    1'b1, 4'h6, 4'h7, 1'b1, 4'h0, 1'b0);
        add_vec("2p4p1",       1'b0, 4'h2, 4'h4, 1'b1, 4'h7, 1'b0);

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].cin);
            @(posedge clk);
            #1;
            check(vecs[i].name, {vecs[i].c, vecs[i].s});
        end

        // exhaustive sweep with a one-cycle reset injected mid-stream
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    if (c == 0 && a == 9 && b == 4) begin
                        @(negedge clk);
                        drive(1'b1, a[3:0], b[3:0], c[0]);
                        exp_q.push_back(5'd0);
                        @(posedge clk);
                        #1;
                        check_from_queue("sweep_mid_reset");
                    end
                    @(negedge clk);
                    drive(1'b0, a[3:0], b[3:0], c[0]);
                    exp_q.push_back(model(a[3:0], b[3:0], c[0]));
                    @(posedge clk);
                    #1;
                    check_from_queue("sweep");
                end
            end
        end

        // glitchy inputs between edges: only the value at the edge counts
        @(negedge clk);
        drive(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        #1;
        drive(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        #1;
        drive(1'b1, 4'hF, 4'hF, 1'b1);
        #1;
        drive(1'b0, 4'h2, 4'h3, 1'b0);
        @(posedge clk);
        #1;
        check("glitch_at_edge", 5'd5);
        for (int k = 0; k < 3; k++) begin
            drive(k[0], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            #1;
        end
        check("glitch_hold_mid", 5'd5);
        @(negedge clk);
        check("glitch_hold_neg", 5'd5);
        drive(1'b0, 4'hC, 4'h4, 1'b0);
        @(posedge clk);
        #1;
        check("glitch_next", 5'h10);

        // reset held across several edges keeps outputs at zero
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
            @(posedge clk);
            #1;
            check("reset_hold", 5'd0);
        end
        @(negedge clk);
        drive(1'b0, 4'h8, 4'h8, 1'b1);
        @(posedge clk);
        #1;
        check("after_reset", 5'h11);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
